// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined, exact multi-mode comparator for the
// {sign, signed exp, unsigned frac} float format.
// Modes: 0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE; 6/7 reserved (out_err=1).
// STAGES selects a 1- or 2-cycle pipeline; any other value fails elaboration.
// Optional: define FP_COMPARE_MINMAX_EN to add out_min/out_max operand outputs.
module fp_compare_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 12,
   parameter int TAG_W  = 4,
   parameter int STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   in_a,
   input  logic [EXP_W+FRAC_W:0]   in_b,
   input  logic [2:0]              in_op,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_result,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    out_err
`ifdef FP_COMPARE_MINMAX_EN
   ,
   output logic [EXP_W+FRAC_W:0]   out_min,
   output logic [EXP_W+FRAC_W:0]   out_max
`endif
);

   localparam int W = 1 + EXP_W + FRAC_W;
   // The most negative exponent is reserved to mean zero.
   localparam logic [EXP_W-1:0] EXP_ZERO = {1'b1, {(EXP_W-1){1'b0}}};

   localparam logic [2:0] OP_GT = 3'd0;
   localparam logic [2:0] OP_GE = 3'd1;
   localparam logic [2:0] OP_LT = 3'd2;
   localparam logic [2:0] OP_LE = 3'd3;
   localparam logic [2:0] OP_EQ = 3'd4;
   localparam logic [2:0] OP_NE = 3'd5;

   // Field-level comparison flags; everything stage 2 needs to finish the job.
   typedef struct packed {
      logic             a_zero;
      logic             b_zero;
      logic             a_sign;
      logic             b_sign;
      logic             exp_gt;
      logic             exp_eq;
      logic             frac_gt;
      logic             frac_eq;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } flags_t;

   // Handshake: a transfer happens on a rising clk edge when valid && ready on
   // the same interface. Every stage advances together on adv; when the output
   // holds an unconsumed result (out_valid && !out_ready) the whole pipe
   // freezes, so in_ready drops and out_* stay stable. Bubbles are overwritten.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   flags_t            s1_d;

   assign a_exp  = in_a[W-2 -: EXP_W];
   assign b_exp  = in_b[W-2 -: EXP_W];
   assign a_frac = in_a[FRAC_W-1:0];
   assign b_frac = in_b[FRAC_W-1:0];

   // Split the operands into field-wise compare flags.
   always_comb begin
      s1_d         = '0;
      s1_d.a_zero  = (a_exp == EXP_ZERO);
      s1_d.b_zero  = (b_exp == EXP_ZERO);
      s1_d.a_sign  = in_a[W-1];
      s1_d.b_sign  = in_b[W-1];
      s1_d.exp_gt  = ($signed(a_exp) > $signed(b_exp));
      s1_d.exp_eq  = (a_exp == b_exp);
      s1_d.frac_gt = (a_frac > b_frac);
      s1_d.frac_eq = (a_frac == b_frac);
      s1_d.op      = in_op;
      s1_d.tag     = in_tag;
   end

   // Source of the resolve stage: stage-1 register or the raw flags.
   flags_t res_flags;
   logic   res_valid;
`ifdef FP_COMPARE_MINMAX_EN
   logic [W-1:0] res_a, res_b;
`endif

   if (STAGES == 2) begin : g_two
      flags_t s1_q;
      logic   s1_valid_q;
`ifdef FP_COMPARE_MINMAX_EN
      logic [W-1:0] s1_a_q, s1_b_q;
`endif

      // Stage 1: capture the compare flags; hold everything while stalled.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
`ifdef FP_COMPARE_MINMAX_EN
            s1_a_q     <= '0;
            s1_b_q     <= '0;
`endif
         end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_q   <= s1_d;
`ifdef FP_COMPARE_MINMAX_EN
               s1_a_q <= in_a;
               s1_b_q <= in_b;
`endif
            end
         end
      end

      assign res_flags = s1_q;
      assign res_valid = s1_valid_q;
`ifdef FP_COMPARE_MINMAX_EN
      assign res_a     = s1_a_q;
      assign res_b     = s1_b_q;
`endif
   end else if (STAGES == 1) begin : g_one
      assign res_flags = s1_d;
      assign res_valid = in_valid;
`ifdef FP_COMPARE_MINMAX_EN
      assign res_a     = in_a;
      assign res_b     = in_b;
`endif
   end else begin : g_bad_stages
      $error("fp_compare_pipe: STAGES must be 1 or 2");
   end

   logic both_zero, mag_eq, mag_gt, a_eq_b, a_gt_b;
   logic result_d, err_d;
`ifdef FP_COMPARE_MINMAX_EN
   logic [W-1:0] min_d, max_d;
`endif

   // Resolve sign and magnitude into GT/EQ, then apply the compare mode.
   always_comb begin
      both_zero = res_flags.a_zero & res_flags.b_zero;
      mag_eq    = both_zero |
                  (~res_flags.a_zero & ~res_flags.b_zero & res_flags.exp_eq & res_flags.frac_eq);
      mag_gt    = ~res_flags.a_zero &
                  (res_flags.b_zero | res_flags.exp_gt | (res_flags.exp_eq & res_flags.frac_gt));
      a_eq_b    = both_zero | ((res_flags.a_sign == res_flags.b_sign) & mag_eq);
      if (both_zero)
         a_gt_b = 1'b0;
      else if (res_flags.a_sign != res_flags.b_sign)
         a_gt_b = ~res_flags.a_sign;
      else if (!res_flags.a_sign)
         a_gt_b = mag_gt;
      else
         a_gt_b = ~mag_gt & ~mag_eq;

      result_d = 1'b0;
      err_d    = 1'b0;
      case (res_flags.op)
         OP_GT:   result_d = a_gt_b;
         OP_GE:   result_d = a_gt_b | a_eq_b;
         OP_LT:   result_d = ~(a_gt_b | a_eq_b);
         OP_LE:   result_d = ~a_gt_b;
         OP_EQ:   result_d = a_eq_b;
         OP_NE:   result_d = ~a_eq_b;
         default: err_d    = 1'b1;
      endcase
`ifdef FP_COMPARE_MINMAX_EN
      // Equal operands fall through to min=A, max=B.
      min_d = a_gt_b ? res_b : res_a;
      max_d = a_gt_b ? res_a : res_b;
`endif
   end

   logic             out_valid_q;
   logic             out_result_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_err_q;
`ifdef FP_COMPARE_MINMAX_EN
   logic [W-1:0]     out_min_q, out_max_q;
`endif

   // Output register: load on advance, hold while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_result_q <= 1'b0;
         out_tag_q    <= '0;
         out_err_q    <= 1'b0;
`ifdef FP_COMPARE_MINMAX_EN
         out_min_q    <= '0;
         out_max_q    <= '0;
`endif
      end else if (adv) begin
         out_valid_q <= res_valid;
         if (res_valid) begin
            out_result_q <= result_d;
            out_tag_q    <= res_flags.tag;
            out_err_q    <= err_d;
`ifdef FP_COMPARE_MINMAX_EN
            out_min_q    <= min_d;
            out_max_q    <= max_d;
`endif
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;
   assign out_err    = out_err_q;
`ifdef FP_COMPARE_MINMAX_EN
   assign out_min    = out_min_q;
   assign out_max    = out_max_q;
`endif

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined multi-mode comparator for the team's sign/exp/frac float format (p_float layout, generalised widths).
- Successor to the single-cycle greater-than: it supports configurable widths and six compare modes, and gives exact results with no precision error.
- Adds a valid/ready handshake with backpressure and a tag passthrough.
- Used by BVH traversal and ray-box slab tests, which issue one compare per cycle and tolerate stalls.

Parameters:
- EXP_W, 8: exponent width; exponent is signed two's complement.
- FRAC_W, 12: fraction width; fraction is unsigned magnitude.
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- STAGES, 2: pipeline depth. Legal values are 1 or 2; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation present
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_a  in  1+EXP_W+FRAC_W  operand A, packed {sign, exp, frac}
- in_b  in  1+EXP_W+FRAC_W  operand B, same packing
- in_op  in  3  mode: 0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE, 6/7 reserved
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_result  out  1  A op B
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  set when in_op was 6 or 7

Behaviour:
- Reset (async assert; deassert sampled on clk): all stage valids 0. out_valid=0, out_result=0, out_tag=0, out_err=0.
- Zero: exp == -2^(EXP_W-1) denotes zero, whatever the frac value.
  - +0 and -0 compare equal.
  - Zero is smaller in magnitude than every non-zero value.
- Magnitude order: larger signed exp is larger. On equal exp, larger frac is larger. Comparison is exact.
- Ordering:
  - Signs differ and not both zero: the positive operand is greater.
  - Both negative: magnitude order is inverted.
  - Equality means identical sign, exp and frac, or both zero.
- Modes: GE = GT|EQ; LT = !GE; LE = !GT; NE = !EQ.
- Reserved op: out_result=0 and out_err=1 for that transaction only. It is not sticky.
- STAGES=2 pipeline:
  - Stage 1 registers the zero flags, sign bits, exp_gt, exp_eq, frac_gt, frac_eq, op and tag.
  - Stage 2 resolves sign and mode into the output register.
- STAGES=1: the whole computation is registered directly into the output register.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stall.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_valid and out_ready.
  - When adv=0, every stage register, including valids, holds.
  - When adv=1, bubbles (valid=0) propagate and are overwritten.
  - out_* stays stable while out_valid && !out_ready.
- Throughput: one operation per cycle when out_ready is held at 1. No bubbles are inserted.
- Simultaneous events:
  - Accept and emit in the same cycle is legal when adv=1.
  - in_valid=0 while adv=1 inserts a bubble.
- Reset mid-operation: all in-flight operations are discarded. No output is produced for them after reset deasserts.

Optional Feature:
- Macro FP_COMPARE_MINMAX_EN.
- Defined:
  - Adds output ports out_min and out_max, each 1+EXP_W+FRAC_W wide.
  - They carry the smaller and larger operand, selected by the same exact ordering and pipelined with the result.
  - On equality, out_min=A and out_max=B.
  - Both are 0 at reset. They are valid whenever out_valid=1, for every op, including reserved ops.
- Undefined: the ports do not exist and the operand datapath is not carried past stage 1.

Test Plan:
- Ordering, STAGES=2, out_ready=1, op=GT:
  - A=+1.5 (exp 0, frac 0x800), B=+1.25 (exp 0, frac 0x400), tag 3 -> out_result=1, tag 3, exactly 2 cycles after accept.
  - Same operands with op=LT -> 0.
- Signed zero and sign handling:
  - A=-0, B=+0 with EQ -> 1; with GT -> 0.
  - A=-2.0, B=-1.0 with LT -> 1.
  - A=-1.0, B=+0 with LE -> 1.
- Back-to-back streaming:
  - Issue 16 random ops over consecutive cycles with out_ready=1 -> 16 results on consecutive cycles, in order, matching a software model.
  - Then issue 10,000 random ops with random in_valid/out_ready -> 0 mismatches.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, and out_result/out_tag are unchanged throughout.
  - Release out_ready -> no operation is lost or duplicated.
- Reserved op and reset:
  - in_op=7 -> out_err=1, out_result=0; the next op=EQ gives out_err=0.
  - Assert rst with 2 operations in flight -> out_valid=0 immediately. No stale result appears after deassert.
- FP_COMPARE_MINMAX_EN defined:
  - A=+3.0, B=-3.0 -> out_min=B, out_max=A.
  - A==B -> out_min=A, out_max=B.
